fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the program counter and drives the multi-cycle instruction memory/cache through a request/done handshake. It accepts redirect (branch/jump), pipeline-stall and HALT inputs from ID and loads the IF/ID instruction register. In-flight fetches are squashed on redirect or halt, and a fetched word is buffered while ID is stalled.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding presented on if_instr when if_valid=0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
pipe_stall  in  1  ID cannot accept an instruction this cycle
branch_taken  in  1  single-cycle redirect request from ID
branch_target  in  16  redirect destination, valid with branch_taken
halt  in  1  HALT decoded in ID
imem_rd  out  1  read request to instruction memory
imem_addr  out  16  fetch address, always equal to pc
imem_stall  in  1  memory busy; request not accepted this cycle
imem_done  in  1  read data valid this cycle
imem_data  in  16  read data
if_instr  out  16  IF/ID instruction register
if_pc  out  16  PC of if_instr
if_pc_2  out  16  if_pc+2, combinational, wraps mod 2^16
if_valid  out  1  if_instr is a real instruction
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=ISSUE, squash=0.
  - if_instr=NOP_INSTR, if_pc=0, if_valid=0, halted=0.
  - Reset mid-transaction abandons it; memory shares the reset.
- States: ISSUE, WAIT, HOLD, DRAIN, HALTED.
- ISSUE:
  - imem_rd=1.
  - If imem_stall=1, stay in ISSUE.
  - Otherwise the request is accepted. If imem_done=1 in the same cycle (hit), this is a delivery. Otherwise go to WAIT.
- WAIT: imem_rd=0. imem_done=1 is a delivery.
- Delivery:
  - If squash=1: discard the data, clear squash, go to ISSUE.
  - If pipe_stall=0: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+2, go to ISSUE.
  - If pipe_stall=1: hold_buf<=imem_data, go to HOLD.
- HOLD:
  - imem_rd=0.
  - When pipe_stall=0: the IF/ID register loads from hold_buf, pc<=pc+2, go to ISSUE.
- IF/ID register in cycles with no load:
  - pipe_stall=1: hold value.
  - Otherwise: if_valid<=0, if_instr<=NOP_INSTR.
- Redirect (branch_taken & ~pipe_stall & ~halt), in ISSUE/WAIT/HOLD:
  - pc<=branch_target.
  - IF/ID register squashed to NOP, if_valid<=0.
  - hold_buf dropped; next state ISSUE.
  - If a fetch was accepted and not yet done (WAIT, or ISSUE accepted without done): squash<=1 and go to WAIT.
  - Delivery in the same cycle as a redirect is discarded.
  - branch_taken together with pipe_stall=1 is ignored; ID re-asserts it.
- Halt (halt & ~pipe_stall): priority over redirect.
  - IF/ID register squashed.
  - Fetch in flight: go to DRAIN, wait for imem_done, discard the data, then go to HALTED.
  - No fetch in flight: go directly to HALTED.
- HALTED:
  - imem_rd=0, halted=1, pc frozen.
  - All inputs ignored until reset.
- Arithmetic: pc increments by 2 mod 2^16 (16'hFFFE -> 16'h0000). branch_target is used unmodified.
- At most one outstanding memory request. imem_rd is never asserted in WAIT, HOLD, DRAIN or HALTED.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {ISSUE, WAIT, HOLD, DRAIN, HALTED}
  - NOP_INSTR default
  - PC_INC=16'h0002
- No new sub-module. pc+2 and if_pc+2 use the existing cla16 adder, instantiated twice.

Test Plan:
- Reset then hits (imem_done with every accepted rd): if_pc = 0,2,4,6 on consecutive cycles, if_valid=1 each, if_pc_2=if_pc+2.
- Miss with done 3 cycles after accept: one imem_rd pulse per fetch, if_valid=1 once per 4 cycles, bubbles show if_instr=16'h0800.
- pipe_stall=1 over a delivery of 16'h1234 at pc=4: IF/ID unchanged, no imem_rd. Stall drops -> if_instr=16'h1234, if_pc=4, next imem_addr=6.
- branch_taken, target 16'h0040, while in WAIT: late imem_done data is never seen on if_instr. Next imem_addr=16'h0040, first valid if_pc=16'h0040.
- halt during WAIT: if_valid=0, DRAIN until done, then halted=1. imem_rd stays 0 afterwards; a later branch_taken has no effect.
- PC wrap and reset:
  - pc=16'hFFFE fetch -> next imem_addr=16'h0000.
  - rst_n=0 mid-WAIT -> outputs reach reset values without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

   typedef enum logic [2:0] {
      ISSUE,
      WAIT,
      HOLD,
      DRAIN,
      HALTED
   } state_t;

   localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
   localparam logic [15:0] PC_INC            = 16'h0002;

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second lookahead level. Purely combinational.
module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g, p, c;
   logic [3:0]  gg, gp, gc;

   assign g = a & b;
   assign p = a ^ b;

   for (genvar k = 0; k < 4; k++) begin : g_grp
      assign gg[k] = g[4*k+3]
                   | (p[4*k+3] & g[4*k+2])
                   | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign gp[k] = &p[4*k+3:4*k];

      assign c[4*k]   = gc[k];
      assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & gc[k]);
      assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
   end

   // Group carries are expanded from cin directly so no group waits on another.
   assign gc[0] = cin;
   assign gc[1] = gg[0] | (gp[0] & cin);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & cin);
   assign cout  = gg[3] | (gp[3] & gc[3]);

   assign sum = p ^ c;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem read at a time, loads IF/ID.
// Hits deliver in the issue cycle; a delivery under pipe_stall is parked in HOLD.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   input  logic        halt,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic        imem_stall,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_2,
   output logic        if_valid,
   output logic        halted
);

   state_t      state, state_nxt;
   logic        squash, squash_nxt;
   logic [15:0] pc, pc_nxt, pc_inc;
   logic [15:0] hold_buf, hold_nxt;
   logic [15:0] instr_nxt, ifpc_nxt;
   logic        valid_nxt;
   logic        pc_cout_unused, ifpc_cout_unused;

   logic accept, pending, in_flight, delivery, halt_go, redirect;

   cla16 u_pc_inc (
      .a    (pc),
      .b    (PC_INC),
      .cin  (1'b0),
      .sum  (pc_inc),
      .cout (pc_cout_unused)
   );

   cla16 u_if_pc_2 (
      .a    (if_pc),
      .b    (PC_INC),
      .cin  (1'b0),
      .sum  (if_pc_2),
      .cout (ifpc_cout_unused)
   );

   assign imem_rd   = (state == ISSUE);
   assign imem_addr = pc;
   assign halted    = (state == HALTED);

   // pending: a request is accepted this cycle or already outstanding.
   assign accept    = (state == ISSUE) & ~imem_stall;
   assign pending   = accept | (state == WAIT);
   assign in_flight = pending & ~imem_done;
   assign delivery  = pending & imem_done;
   assign halt_go   = halt & ~pipe_stall;
   assign redirect  = branch_taken & ~pipe_stall & ~halt;

   always_comb begin
      state_nxt  = state;
      squash_nxt = squash;
      pc_nxt     = pc;
      hold_nxt   = hold_buf;
      instr_nxt  = if_instr;
      ifpc_nxt   = if_pc;
      valid_nxt  = if_valid;

      case (state)
         ISSUE, WAIT, HOLD: begin
            if (!pipe_stall) begin
               valid_nxt = 1'b0;
               instr_nxt = NOP_INSTR;
            end

            if (halt_go) begin
               squash_nxt = 1'b0;
               state_nxt  = in_flight ? DRAIN : HALTED;
            end else if (redirect) begin
               // A request still outstanding must be drained and thrown away.
               pc_nxt     = branch_target;
               squash_nxt = in_flight;
               state_nxt  = in_flight ? WAIT : ISSUE;
            end else if (delivery) begin
               state_nxt = ISSUE;
               if (squash) begin
                  squash_nxt = 1'b0;
               end else if (!pipe_stall) begin
                  instr_nxt = imem_data;
                  ifpc_nxt  = pc;
                  valid_nxt = 1'b1;
                  pc_nxt    = pc_inc;
               end else begin
                  hold_nxt  = imem_data;
                  state_nxt = HOLD;
               end
            end else if (accept) begin
               state_nxt = WAIT;
            end else if ((state == HOLD) && !pipe_stall) begin
               instr_nxt = hold_buf;
               ifpc_nxt  = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc_inc;
               state_nxt = ISSUE;
            end
         end
         DRAIN: begin
            if (imem_done) begin
               state_nxt = HALTED;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ISSUE;
         squash   <= 1'b0;
         pc       <= RESET_PC;
         hold_buf <= '0;
         if_instr <= NOP_INSTR;
         if_pc    <= '0;
         if_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         squash   <= squash_nxt;
         pc       <= pc_nxt;
         hold_buf <= hold_nxt;
         if_instr <= instr_nxt;
         if_pc    <= ifpc_nxt;
         if_valid <= valid_nxt;
      end
   end

endmodule
